// File: rtl/color_msg_scheduler.sv
// color_msg_scheduler: arbitrates 3-byte color messages ('C', color char, CR) and
//   single debug bytes onto a uart_tx start/done handshake, one byte in flight.
// Latency: color_valid seen in IDLE -> tx_start 2 cycles later; GAP_CYCLES idle after each tx_done.
// Backpressure: one pending color slot (latest wins, overrun pulsed); debug holds dbg_req until dbg_ack.
// Ports: clk_3125_i / reset_i       sole clock, async active-high reset
//        color_valid_i/color_code_i color result pulse and code
//        dbg_req_i/dbg_data_i/dbg_ack_o debug byte request / grant handshake
//        tx_start_o/tx_data_o/parity_type_o/tx_done_i  uart_tx side
//        busy_o, color_overrun_o, err_timeout_o        status
// Parameter ranges assumed: INIT_CYCLES >= 1, GAP_CYCLES >= 1, TIMEOUT_CYCLES >= 2, all < 65536.
module color_msg_scheduler #(
  parameter int unsigned PARITY_TYPE    = 0,
  parameter int unsigned GAP_CYCLES     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned INIT_CYCLES    = 160
) (
  input  logic       clk_3125_i,
  input  logic       reset_i,
  input  logic       color_valid_i,
  input  logic [1:0] color_code_i,
  input  logic       dbg_req_i,
  input  logic [7:0] dbg_data_i,
  output logic       dbg_ack_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       parity_type_o,
  input  logic       tx_done_i,
  output logic       busy_o,
  output logic       color_overrun_o,
  output logic       err_timeout_o
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;            // byte index within current message
  logic [1:0]       last_idx_q, last_idx_d;  // index of final byte (2 color, 0 debug)
  logic [1:0]       msg_code_q, msg_code_d;  // color code of the in-flight message
  logic [7:0]       tx_data_q, tx_data_d;
  logic             col_pend_q, col_pend_d;
  logic [1:0]       col_code_q, col_code_d;  // latest unsent color code
  logic             dbg_pend_q, dbg_pend_d;
  logic             last_dbg_q, last_dbg_d;  // 1: debug won the last contested grant
  logic             err_q, err_d;
  logic             grant_col, grant_dbg, overrun;

  function automatic logic [7:0] color_byte(input logic [1:0] idx, input logic [1:0] code);
    logic [7:0] b;
    case (idx)
      2'd0: b = 8'h43;
      2'd1: begin
        case (code)
          2'd0:    b = 8'h52;
          2'd1:    b = 8'h47;
          2'd2:    b = 8'h42;
          default: b = 8'h57;
        endcase
      end
      default: b = 8'h0D;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    msg_code_d = msg_code_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    last_dbg_d = last_dbg_q;
    grant_col  = 1'b0;
    grant_dbg  = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        // The round-robin pointer only moves when both sources compete, so an
        // uncontested grant never steals the other source's next turn.
        if (col_pend_q && dbg_pend_q) begin
          grant_col  = last_dbg_q;
          grant_dbg  = !last_dbg_q;
          last_dbg_d = !last_dbg_q;
        end else begin
          grant_col = col_pend_q;
          grant_dbg = dbg_pend_q;
        end
        if (grant_col) begin
          state_d    = S_ISSUE;
          idx_d      = 2'd0;
          last_idx_d = 2'd2;
          msg_code_d = col_code_q;
          tx_data_d  = 8'h43;
        end else if (grant_dbg) begin
          state_d    = S_ISSUE;
          idx_d      = 2'd0;
          last_idx_d = 2'd0;
          tx_data_d  = dbg_data_i;
        end
      end
      S_ISSUE: begin
        // The start cycle counts toward the timeout budget.
        state_d = S_WAIT;
        cnt_d   = CNT_W'(1);
      end
      S_WAIT: begin
        if (tx_done_i) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          last_idx_d = idx_q;  // drop the rest of the message
          state_d    = S_GAP;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q != last_idx_q) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = color_byte(idx_q + 2'd1, msg_code_q);
            state_d   = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase

    // A color_valid in the grant cycle re-arms pending for the next message.
    col_pend_d = grant_col ? 1'b0 : col_pend_q;
    col_code_d = col_code_q;
    overrun    = 1'b0;
    if (color_valid_i) begin
      col_pend_d = 1'b1;
      col_code_d = color_code_i;
      overrun    = col_pend_q && !grant_col;
    end
    dbg_pend_d = grant_dbg ? 1'b0 : (dbg_pend_q || dbg_req_i);
  end

  always_ff @(posedge clk_3125_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      msg_code_q <= '0;
      tx_data_q  <= '0;
      col_pend_q <= 1'b0;
      col_code_q <= '0;
      dbg_pend_q <= 1'b0;
      last_dbg_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      msg_code_q <= msg_code_d;
      tx_data_q  <= tx_data_d;
      col_pend_q <= col_pend_d;
      col_code_q <= col_code_d;
      dbg_pend_q <= dbg_pend_d;
      last_dbg_q <= last_dbg_d;
      err_q      <= err_d;
    end
  end

  assign tx_start_o      = (state_q == S_ISSUE);
  assign busy_o          = (state_q != S_IDLE);
  assign tx_data_o       = tx_data_q;
  assign dbg_ack_o       = grant_dbg;
  assign color_overrun_o = overrun;
  assign err_timeout_o   = err_q;
  assign parity_type_o   = 1'(PARITY_TYPE);

endmodule

// File: tb/tb_color_msg_scheduler.sv
// tb_color_msg_scheduler: directed checks of color_msg_scheduler with a small uart_tx responder.
// Latency: n/a (bench).
// Backpressure: responder answers each tx_start with tx_done LAT cycles later when enabled.
module tb_color_msg_scheduler;
  localparam int INIT = 10;
  localparam int GAP  = 3;
  localparam int TMO  = 20;
  localparam int LAT  = 4;

  logic       clk = 1'b0;
  logic       reset, color_valid, dbg_req, dbg_ack, tx_start, parity_type, tx_done;
  logic       busy, color_overrun, err_timeout;
  logic [1:0] color_code;
  logic [7:0] dbg_data, tx_data;
  logic       uart_done, stray_done, uart_en, drop_req;

  always #5 clk = ~clk;
  assign tx_done = uart_done | stray_done;

  color_msg_scheduler #(
    .PARITY_TYPE(1), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .INIT_CYCLES(INIT)
  ) dut (
    .clk_3125_i(clk), .reset_i(reset), .color_valid_i(color_valid), .color_code_i(color_code),
    .dbg_req_i(dbg_req), .dbg_data_i(dbg_data), .dbg_ack_o(dbg_ack), .tx_start_o(tx_start),
    .tx_data_o(tx_data), .parity_type_o(parity_type), .tx_done_i(tx_done), .busy_o(busy),
    .color_overrun_o(color_overrun), .err_timeout_o(err_timeout)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] q_byte[$];
  int         q_start[$];
  int         q_done[$];
  int         n_ack = 0;
  int         n_ovr = 0;
  int         err_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    if (tx_start) begin
      q_byte.push_back(tx_data);
      q_start.push_back(cyc);
    end
    if (uart_done) q_done.push_back(cyc);
    if (dbg_ack) n_ack <= n_ack + 1;
    if (color_overrun) n_ovr <= n_ovr + 1;
    if (err_timeout && err_cyc < 0) err_cyc <= cyc;
  end

  // uart_tx stand-in: tx_done LAT cycles after each tx_start.
  initial begin
    int lat;
    lat = -1;
    uart_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      uart_done = 1'b0;
      if (lat == 0) begin
        uart_done = 1'b1;
        lat = -1;
      end else if (lat > 0) begin
        lat--;
      end
      if (tx_start && uart_en) lat = LAT - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: pulses drop, requester releases dbg_req the cycle after its ack.
  task automatic tick;
    @(posedge clk); #1;
    color_valid = 1'b0;
    stray_done  = 1'b0;
    if (drop_req) begin
      dbg_req  = 1'b0;
      drop_req = 1'b0;
    end
    #1;
    if (dbg_ack) drop_req = 1'b1;
  endtask

  // which: 0 = tx_start count, 1 = tx_done count
  task automatic wait_cnt(input string tag, input int which, input int n, input int budget);
    int k;
    k = 0;
    while (((which == 0) ? q_start.size() : q_done.size()) < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(((which == 0) ? q_start.size() : q_done.size()) >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int at);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < budget);
    chk(tag, 32'(busy), 32'd0);
    at = cyc;
  endtask

  // exp holds byte i in bits [8i+7:8i].
  task automatic chk_bytes(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [31:0] got;
    chk({tag, "_count"}, q_byte.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < q_byte.size()) ? 32'(q_byte[base + i]) : 32'hDEAD;
      chk($sformatf("%s_b%0d", tag, i), got, 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, v, b, d, t, i1, a0, o0;
    reset = 1'b1; color_valid = 1'b0; color_code = 2'd0; dbg_req = 1'b0; dbg_data = 8'h00;
    stray_done = 1'b0; uart_en = 1'b1; drop_req = 1'b0;

    // Reset state and INIT length
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_overrun", color_overrun, 0);
    chk("rst_err", err_timeout, 0);
    chk("parity_type", parity_type, 1);
    tick(); reset = 1'b0; r = cyc;
    wait_idle("init_wait", 50, t);
    chk("init_len", t - r, INIT);
    chk("init_no_start", q_start.size(), 0);

    // Color code 1; a new color_valid mid-message queues a second message
    b = q_byte.size(); d = q_done.size(); o0 = n_ovr;
    tick(); color_valid = 1'b1; color_code = 2'd1; v = cyc;
    wait_cnt("t1_s2", 0, b + 2, 60);
    color_valid = 1'b1; color_code = 2'd2;
    wait_idle("t1_idle1", 60, i1);
    wait_idle("t1_idle2", 80, t);
    chk("t1_latency", q_start[b] - v, 2);
    chk("t1_gap0", q_start[b+1] - q_done[d], GAP + 1);
    chk("t1_gap1", q_start[b+2] - q_done[d+1], GAP + 1);
    chk("t1_tail", i1 - q_done[d+2], GAP + 1);
    chk("t1_regrant", q_start[b+3] - i1, 1);
    chk_bytes("t1", b, 6, 64'h0D_42_43_0D_47_43);
    chk("t1_no_overrun", n_ovr - o0, 0);

    // Simultaneous color + debug: color first, then debug first next time
    b = q_byte.size(); a0 = n_ack;
    tick(); color_valid = 1'b1; color_code = 2'd0; dbg_req = 1'b1; dbg_data = 8'hA5;
    wait_cnt("t2a_s4", 0, b + 4, 120);
    wait_idle("t2a_idle", 40, t);
    chk_bytes("t2a", b, 4, 64'hA5_0D_52_43);
    chk("t2a_ack", n_ack - a0, 1);
    b = q_byte.size(); a0 = n_ack;
    tick(); color_valid = 1'b1; color_code = 2'd2; dbg_req = 1'b1; dbg_data = 8'h3C;
    wait_cnt("t2b_s4", 0, b + 4, 120);
    wait_idle("t2b_idle", 40, t);
    chk_bytes("t2b", b, 4, 64'h0D_42_43_3C);
    chk("t2b_ack", n_ack - a0, 1);

    // Two color results during INIT: one overrun, latest code wins
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; r = cyc; b = q_byte.size(); o0 = n_ovr;
    tick(); tick(); color_valid = 1'b1; color_code = 2'd2;
    tick(); tick(); color_valid = 1'b1; color_code = 2'd3;
    wait_cnt("t3_s1", 0, b + 1, 60);
    wait_idle("t3_idle", 60, t);
    chk("t3_overrun", n_ovr - o0, 1);
    chk("t3_first_start", q_start[b] - r, INIT + 1);
    chk_bytes("t3", b, 3, 64'h0D_57_43);

    // tx_done never arrives: timeout, remaining bytes dropped
    uart_en = 1'b0; b = q_byte.size();
    tick(); color_valid = 1'b1; color_code = 2'd3;
    wait_cnt("t4_s1", 0, b + 1, 20);
    wait_idle("t4_idle", 100, t);
    chk_bytes("t4", b, 1, 64'h43);
    chk("t4_err_at", err_cyc - q_start[b], TMO);
    chk("t4_idle_at", t - err_cyc, GAP);
    chk("t4_err_set", err_timeout, 1);

    // color_valid in the grant cycle re-arms pending without overrun
    uart_en = 1'b1; b = q_byte.size(); o0 = n_ovr;
    tick(); color_valid = 1'b1; color_code = 2'd1; v = cyc;
    tick(); color_valid = 1'b1; color_code = 2'd2;
    wait_cnt("t4b_s4", 0, b + 4, 120);
    wait_idle("t4b_idle", 60, t);
    chk("t4b_overrun", n_ovr - o0, 0);
    chk("t4b_latency", q_start[b] - v, 2);
    chk_bytes("t4b", b, 6, 64'h0D_42_43_0D_47_43);
    chk("t4b_err_sticky", err_timeout, 1);

    // Reset during the second byte, with another color pending
    b = q_byte.size();
    tick(); color_valid = 1'b1; color_code = 2'd0;
    wait_cnt("t5_s2", 0, b + 2, 60);
    color_valid = 1'b1; color_code = 2'd2;
    tick(); reset = 1'b1; #1;
    chk("t5_busy", busy, 1);
    chk("t5_tx_start", tx_start, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_err_clr", err_timeout, 0);
    tick(); reset = 1'b0; r = cyc;
    wait_idle("t5_idle", 60, t);
    chk("t5_init_len", t - r, INIT);
    chk("t5_no_leftover", q_start.size() - b, 2);
    repeat (8) tick();
    chk("t5_pending_clr", busy, 0);
    chk("t5_still_none", q_start.size() - b, 2);

    // Stray tx_done in IDLE and in GAP
    b = q_byte.size();
    tick(); stray_done = 1'b1;
    repeat (3) tick();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_nostart", q_start.size() - b, 0);
    d = q_done.size();
    tick(); color_valid = 1'b1; color_code = 2'd1;
    wait_cnt("t6_d1", 1, d + 1, 60);
    stray_done = 1'b1;
    wait_cnt("t6_s3", 0, b + 3, 80);
    wait_idle("t6_idle", 60, t);
    chk_bytes("t6", b, 3, 64'h0D_47_43);
    chk("t6_gap", q_start[b+1] - q_done[d], GAP + 1);
    chk("t6_tail", t - q_done[d+2], GAP + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/color_msg_scheduler.md
COLOR_MSG_SCHEDULER -- requirements
Module: color_msg_scheduler

Interface
REQ-001 SHALL have parameter PARITY_TYPE, default 0, driven unchanged onto parity_type (0 even, 1 odd).
REQ-002 SHALL have parameter GAP_CYCLES, default 14, giving idle cycles inserted after each byte's tx_done.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for tx_done per byte.
REQ-004 SHALL have parameter INIT_CYCLES, default 160, giving the post-reset wait that lets a non-resettable uart_tx finish any in-flight frame.
REQ-005 clk_3125  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 color_valid  input  1  one-cycle pulse: new color result available.
REQ-008 color_code  input  2  0 red, 1 green, 2 blue, 3 white/none; sampled with color_valid.
REQ-009 dbg_req  input  1  level: debug byte waiting, held until dbg_ack.
REQ-010 dbg_data  input  8  debug byte, stable while dbg_req is high.
REQ-011 dbg_ack  output  1  one-cycle pulse: debug request granted, dbg_data captured.
REQ-012 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-013 tx_data  output  8  byte to uart_tx, stable from tx_start until tx_done.
REQ-014 parity_type  output  1  constant PARITY_TYPE.
REQ-015 tx_done  input  1  one-cycle completion pulse from uart_tx.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 color_overrun  output  1  one-cycle pulse when a pending color result is overwritten.
REQ-018 err_timeout  output  1  sticky, set on tx_done timeout, cleared only by reset.

Function
REQ-019 SHALL implement states INIT, IDLE, ISSUE, WAIT, GAP.
REQ-020 Color message SHALL be 3 bytes in order: 0x43 ('C'), color char (0x52/0x47/0x42/0x57 for code 0/1/2/3), 0x0D.
REQ-021 Debug message SHALL be 1 byte: the dbg_data captured at grant.
REQ-022 color_valid SHALL set a pending flag and latch color_code; if pending is already set, it SHALL overwrite the latched code (latest wins) and pulse color_overrun.
REQ-023 A color_valid arriving while a color message is transmitting SHALL set pending for a later message and SHALL NOT alter the in-flight bytes.
REQ-024 INIT: counts INIT_CYCLES, then moves to IDLE; requests are latched but not granted.
REQ-025 IDLE: if only one source is pending, grant it; if both, grant the source not granted last (round-robin, last_grant resets to debug so color wins first).
REQ-026 A color grant SHALL clear the color pending flag in the grant cycle; a color_valid in the same cycle SHALL set it again without an overrun pulse.
REQ-027 A debug grant SHALL pulse dbg_ack in the grant cycle and capture dbg_data.
REQ-028 IDLE to ISSUE on grant; tx_data is loaded on the same edge.
REQ-029 ISSUE: tx_start high for exactly one cycle, then WAIT.
REQ-030 WAIT: on tx_done go to GAP; a tx_done in any other state SHALL be ignored.
REQ-031 WAIT: if TIMEOUT_CYCLES elapse without tx_done, set err_timeout, abort the message (remaining bytes dropped), go to GAP.
REQ-032 GAP: count GAP_CYCLES; then ISSUE with the next byte if any remain, else IDLE.
REQ-033 From color_valid sampled with the block in IDLE and nothing else pending, tx_start SHALL rise 2 cycles later.
REQ-034 Byte index SHALL be 2 bits; no wrap beyond index 2.

Reset
REQ-035 While reset is high: state INIT, tx_start 0, tx_data 0x00, dbg_ack 0, color_overrun 0, err_timeout 0, busy 1, pending flags 0, last_grant = debug, all counters 0.
REQ-036 Reset asserted mid-message SHALL abort immediately; after release the block SHALL wait INIT_CYCLES before any tx_start.

Verification
REQ-037 Reset release, color_valid with code 1 after INIT -> bytes 0x43, 0x47, 0x0D each on one tx_start pulse, GAP_CYCLES between each tx_done and the next tx_start; busy falls after the last gap.
REQ-038 color_valid code 0 and dbg_req 0xA5 in the same IDLE cycle -> color message first, then 0xA5 with one dbg_ack; a second simultaneous request pair -> debug first.
REQ-039 Two color_valid pulses (codes 2, then 3) before any grant, e.g. during INIT -> one color_overrun pulse, a single message with color byte 0x57.
REQ-040 tx_done held low after tx_start -> err_timeout set TIMEOUT_CYCLES later, remaining bytes dropped, return to IDLE; err_timeout stays high until reset.
REQ-041 Reset pulsed during the second color byte -> tx_start stays low for INIT_CYCLES after release, no leftover bytes sent, pending cleared.
REQ-042 Stray tx_done pulse in IDLE or GAP -> no state change, no extra tx_start.
